// File: rtl/bus_mem_responder.sv
// Memory-side responder for the CPU multiplexed address/data bus: latches an address,
// then services single-cycle reads/writes against a tagged word array.
// Optional: define BUS_MEM_ADDR_INC_EN to post-increment the address after each access.
module bus_mem_responder #(
  parameter int ADDR_W = 20,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [63:0]      i_ad,
  input  logic [7:0]       i_tag,
  input  logic             i_astb,
  input  logic             i_rd,
  input  logic             i_wr,
  output logic [63:0]      o_data,
  output logic [7:0]       o_tag,
  output logic             o_err,
  output logic [CNT_W-1:0] o_rd_cnt,
  output logic [CNT_W-1:0] o_wr_cnt
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ARMED = 1'b1
  } state_t;

  state_t            state, next_state;
  logic [ADDR_W-1:0] addr;
  logic              proto_err, addr_ld, acc_rd, acc_wr;

  logic [71:0] mem [0:(1<<ADDR_W)-1];

  // NOTE: sequential state is written with non-blocking assignments only, so every
  // register samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // Decode one bus cycle: at most one of address load, read, write or error fires.
  // NOTE: every output of this block gets a default first, otherwise paths that do not
  // assign it would infer a latch.
  always_comb begin
    next_state = state;
    proto_err  = 1'b0;
    addr_ld    = 1'b0;
    acc_rd     = 1'b0;
    acc_wr     = 1'b0;
    if (i_rd || i_wr) begin
      if (i_astb || (i_rd && i_wr) || state == S_IDLE) proto_err = 1'b1;
      else if (i_rd)                                    acc_rd    = 1'b1;
      else                                              acc_wr    = 1'b1;
    end else if (i_astb) begin
      addr_ld    = 1'b1;
      next_state = S_ARMED;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr     <= '0;
      o_data   <= '0;
      o_tag    <= '0;
      o_err    <= 1'b0;
      o_rd_cnt <= '0;
      o_wr_cnt <= '0;
    end else begin
      if (proto_err) o_err <= 1'b1;
      if (addr_ld)   addr  <= i_ad[ADDR_W-1:0];
      if (acc_rd) begin
        {o_tag, o_data} <= mem[addr];
        if (o_rd_cnt != '1) o_rd_cnt <= o_rd_cnt + CNT_W'(1);
      end
      if (acc_wr && o_wr_cnt != '1) o_wr_cnt <= o_wr_cnt + CNT_W'(1);
`ifdef BUS_MEM_ADDR_INC_EN
      // Natural ADDR_W-bit overflow gives the wrap from the top word to 0.
      if (acc_rd || acc_wr) addr <= addr + ADDR_W'(1);
`else
`endif
    end
  end

  // NOTE: the array is deliberately left out of reset so it maps onto block RAM;
  // only the write enable honours reset.
  always_ff @(posedge clk) begin
    if (!reset && acc_wr) mem[addr] <= {i_tag, i_ad};
  end

endmodule

// File: tb/tb_bus_mem_responder.sv
// Directed self-checking bench for bus_mem_responder; expectations follow
// BUS_MEM_ADDR_INC_EN when the bench is built with it.
module tb_bus_mem_responder;

`ifdef BUS_MEM_ADDR_INC_EN
  localparam bit INC = 1'b1;
`else
  localparam bit INC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] ad = '0;
  logic [7:0]  tag = '0;
  logic        astb = 1'b0, rd = 1'b0, wr = 1'b0;
  logic [63:0] o_data;
  logic [7:0]  o_tag;
  logic        o_err;
  logic [31:0] o_rd_cnt, o_wr_cnt;

  // Small instance used only for counter saturation.
  logic        s_reset = 1'b1;
  logic [63:0] s_ad = '0;
  logic        s_astb = 1'b0, s_rd = 1'b0, s_wr = 1'b0;
  logic [63:0] s_data;
  logic [7:0]  s_tag;
  logic        s_err;
  logic [3:0]  s_rd_cnt, s_wr_cnt;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  bus_mem_responder dut (
    .clk(clk), .reset(reset), .i_ad(ad), .i_tag(tag), .i_astb(astb), .i_rd(rd), .i_wr(wr),
    .o_data(o_data), .o_tag(o_tag), .o_err(o_err), .o_rd_cnt(o_rd_cnt), .o_wr_cnt(o_wr_cnt)
  );

  bus_mem_responder #(.ADDR_W(4), .CNT_W(4)) dut_s (
    .clk(clk), .reset(s_reset), .i_ad(s_ad), .i_tag(8'h00), .i_astb(s_astb), .i_rd(s_rd),
    .i_wr(s_wr), .o_data(s_data), .o_tag(s_tag), .o_err(s_err), .o_rd_cnt(s_rd_cnt),
    .o_wr_cnt(s_wr_cnt)
  );

  task automatic chk(input string name, input logic [71:0] obs, input logic [71:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
  endtask

  // One bus cycle on the main instance; inputs return to idle after the edge.
  task automatic cyc(input logic a, input logic r, input logic w,
                     input logic [63:0] d, input logic [7:0] t);
    astb = a; rd = r; wr = w; ad = d; tag = t;
    @(posedge clk); #1;
    astb = 1'b0; rd = 1'b0; wr = 1'b0;
  endtask

  task automatic s_cyc(input logic a, input logic r, input logic w, input logic [63:0] d);
    s_astb = a; s_rd = r; s_wr = w; s_ad = d;
    @(posedge clk); #1;
    s_astb = 1'b0; s_rd = 1'b0; s_wr = 1'b0;
  endtask

  initial begin
    // Reset, then idle.
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    cyc(0, 0, 0, 64'h0, 8'h0);
    chk("rst_data",   o_data,   64'h0);
    chk("rst_tag",    o_tag,    8'h0);
    chk("rst_err",    o_err,    1'b0);
    chk("rst_rd_cnt", o_rd_cnt, 32'd0);
    chk("rst_wr_cnt", o_wr_cnt, 32'd0);

    // Read without a strobe is a protocol error.
    cyc(0, 1, 0, 64'h0, 8'h0);
    chk("idle_rd_err",    o_err,    1'b1);
    chk("idle_rd_cnt",    o_rd_cnt, 32'd0);
    chk("idle_rd_data",   o_data,   64'h0);
    reset = 1'b1; @(posedge clk); #1 reset = 1'b0;
    chk("err_cleared",    o_err,    1'b0);

    // Basic write then read.
    cyc(1, 0, 0, 64'h12345, 8'h0);
    cyc(0, 0, 1, 64'hDEADBEEF_00C0FFEE, 8'h5A);
    chk("wr_cnt1",        o_wr_cnt, 32'd1);
    chk("wr_data_hold",   o_data,   64'h0);
    cyc(1, 0, 0, 64'h12345, 8'h0);
    cyc(0, 1, 0, 64'h0, 8'h0);
    chk("rd_data",        o_data,   64'hDEADBEEF_00C0FFEE);
    chk("rd_tag",         o_tag,    8'h5A);
    chk("rd_cnt1",        o_rd_cnt, 32'd1);
    chk("rd_err",         o_err,    1'b0);

    // Second word at address 1, then alias of 0x12345 through ignored upper bits.
    cyc(1, 0, 0, 64'h1, 8'h0);
    cyc(0, 0, 1, 64'h1111_2222_3333_4444, 8'h11);
    cyc(1, 0, 0, 64'h1, 8'h0);
    cyc(0, 1, 0, 64'h0, 8'h0);
    chk("rd_a1_data",     o_data,   64'h1111_2222_3333_4444);
    cyc(1, 0, 0, 64'hFFFF_0000_0001_2345, 8'h0);
    cyc(0, 1, 0, 64'h0, 8'h0);
    chk("alias_data",     o_data,   64'hDEADBEEF_00C0FFEE);
    chk("alias_tag",      o_tag,    8'h5A);
    chk("alias_rd_cnt",   o_rd_cnt, 32'd3);
    chk("alias_wr_cnt",   o_wr_cnt, 32'd2);

    // Protocol errors in ARMED: no write, no address change, no counter change.
    cyc(1, 0, 0, 64'h12345, 8'h0);
    cyc(0, 1, 1, 64'h0BAD, 8'hEE);
    chk("rdwr_err",       o_err,    1'b1);
    chk("rdwr_data",      o_data,   64'hDEADBEEF_00C0FFEE);
    chk("rdwr_rd_cnt",    o_rd_cnt, 32'd3);
    chk("rdwr_wr_cnt",    o_wr_cnt, 32'd2);
    cyc(1, 1, 0, 64'h1, 8'h0);
    cyc(1, 0, 1, 64'h12345, 8'hEE);
    chk("astb_acc_data",  o_data,   64'hDEADBEEF_00C0FFEE);
    chk("astb_acc_wrcnt", o_wr_cnt, 32'd2);
    cyc(0, 1, 0, 64'h0, 8'h0);
    chk("post_err_data",  o_data,   64'hDEADBEEF_00C0FFEE);
    chk("post_err_tag",   o_tag,    8'h5A);
    chk("post_err_rdcnt", o_rd_cnt, 32'd4);
    chk("err_sticky",     o_err,    1'b1);

    // Reset wins over a simultaneous read.
    reset = 1'b1; rd = 1'b1;
    @(posedge clk); #1 reset = 1'b0; rd = 1'b0;
    chk("mid_rst_data",   o_data,   64'h0);
    chk("mid_rst_tag",    o_tag,    8'h0);
    chk("mid_rst_err",    o_err,    1'b0);
    chk("mid_rst_rdcnt",  o_rd_cnt, 32'd0);
    chk("mid_rst_wrcnt",  o_wr_cnt, 32'd0);

    // Top-of-array boundary with back-to-back writes.
    cyc(1, 0, 0, 64'h0, 8'h0);
    cyc(0, 0, 1, 64'hAAAA, 8'h33);
    cyc(1, 0, 0, 64'hFFFFF, 8'h0);
    cyc(0, 0, 1, 64'h1, 8'h00);
    cyc(0, 0, 1, 64'h2, 8'h00);
    chk("top_wr_cnt",     o_wr_cnt, 32'd3);
    cyc(1, 0, 0, 64'hFFFFF, 8'h0);
    cyc(0, 1, 0, 64'h0, 8'h0);
    chk("top_word",       o_data,   INC ? 64'h1 : 64'h2);
    cyc(1, 0, 0, 64'h0, 8'h0);
    cyc(0, 1, 0, 64'h0, 8'h0);
    chk("wrap_word",      o_data,   INC ? 64'h2 : 64'hAAAA);
    chk("wrap_tag",       o_tag,    INC ? 8'h00 : 8'h33);
    chk("top_rd_cnt",     o_rd_cnt, 32'd2);

    // Counter saturation on the 4-bit instance.
    @(posedge clk); #1 s_reset = 1'b0;
    chk("s_rst_rdcnt",    s_rd_cnt, 4'd0);
    s_cyc(1, 0, 0, 64'h0);
    for (int i = 0; i < 17; i++) s_cyc(0, 0, 1, 64'(i));
    chk("s_wr_sat",       s_wr_cnt, 4'd15);
    s_cyc(1, 0, 0, 64'h0);
    for (int i = 0; i < 14; i++) s_cyc(0, 1, 0, 64'h0);
    chk("s_rd_14",        s_rd_cnt, 4'd14);
    for (int i = 0; i < 3; i++) s_cyc(0, 1, 0, 64'h0);
    chk("s_rd_sat",       s_rd_cnt, 4'd15);
    chk("s_err",          s_err,    1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bus_mem_responder.md
Name: bus_mem_responder

Overview:
- Memory-side responder for the CPU external bus; the other end of the CPU's address/data interface.
- The CPU drives a multiplexed 64-bit address/data bus with an 8-bit tag, an address strobe, and read and write strobes. This block latches addresses, services reads and writes against an internal tagged word array, and returns read data and tag to the CPU data inputs.
- Used as the memory model in CPU testbenches, and as the synthesizable RAM front-end on FPGA builds.

Parameters:
- ADDR_W, 20, word-address width. Array depth is 2**ADDR_W words of 64+8 bits.
- CNT_W, 32, width of the access counters.

Ports:
- clk  input  1  system clock; all logic acts on the rising edge.
- reset  input  1  synchronous, active-high reset.
- i_ad  input  64  CPU address/data bus (CPU o_ad).
- i_tag  input  8  CPU tag output (CPU o_tag).
- i_astb  input  1  address strobe.
- i_rd  input  1  read request.
- i_wr  input  1  write request.
- o_data  output  64  read data to CPU (CPU i_data).
- o_tag  output  8  read tag to CPU (CPU i_tag).
- o_err  output  1  sticky protocol-error flag.
- o_rd_cnt  output  CNT_W  count of accepted reads.
- o_wr_cnt  output  CNT_W  count of accepted writes.

Behaviour:
- Reset (clk edge with reset=1): state IDLE, latched address 0, o_data 0, o_tag 0, o_err 0, both counters 0. Array contents are not reset. Reset wins over every other input on the same edge.
- States:
  - IDLE: no valid address.
  - ARMED: address latched.
- i_astb=1 with i_rd=0 and i_wr=0:
  - addr <= i_ad[ADDR_W-1:0]; upper bits are ignored, so addresses wrap.
  - Next state ARMED, from either state.
  - A re-strobe in ARMED replaces the address.
- ARMED, i_rd=1 alone:
  - On that edge, o_data/o_tag <= mem[addr] (registered, one-cycle latency); the CPU samples the value on the following edge.
  - o_data/o_tag hold until the next accepted read.
  - o_rd_cnt increments.
- ARMED, i_wr=1 alone:
  - mem[addr] <= {i_tag, i_ad} on that edge.
  - o_data/o_tag are unchanged.
  - o_wr_cnt increments.
  - A read of the same address on the next cycle returns the new value.
- State after a data access: remains ARMED; the address is unchanged unless ADDR_INC_EN is defined.
- Protocol errors set o_err and cause no array write, no o_data change and no counter change:
  - i_rd or i_wr in IDLE.
  - i_rd and i_wr together.
  - i_astb together with i_rd or i_wr.
  - The address and state are also unchanged.
- o_err is cleared only by reset.
- Counters saturate at all-ones and never wrap.
- No wait states: every accepted access completes in one cycle, so the CPU may issue back-to-back rd/wr.

Optional Feature:
- Macro: BUS_MEM_ADDR_INC_EN.
- Defined: every accepted read or write post-increments the latched address by 1 modulo 2**ADDR_W, which allows block transfers with one strobe. Address 2**ADDR_W-1 wraps to 0.
- Not defined: the address stays fixed until the next i_astb, so repeated reads return the same word.

Test Plan:
- Reset, then idle → o_data=0, o_tag=0, o_err=0, counters 0. Assert i_rd without a strobe → o_err=1, o_rd_cnt=0.
- Strobe i_ad=0x12345; write i_ad=0xDEADBEEF_00C0FFEE, i_tag=0x5A; then read → after the read edge o_data=0xDEADBEEF_00C0FFEE, o_tag=0x5A; o_wr_cnt=1, o_rd_cnt=1.
- Strobe i_ad=0xFFFF_0000_0001_2345 → aliases address 0x12345; a read returns the previous test's word (upper address bits ignored).
- Assert i_rd and i_wr together in ARMED → o_err=1; array word, o_data and counters unchanged. Reset mid-sequence → all outputs return to 0.
- Strobe address 0xFFFFF, write 0x1, write 0x2 (macro on) → mem[0xFFFFF]=1, mem[0]=2. With the macro off → mem[0xFFFFF]=2 and mem[0] untouched.
- Force o_rd_cnt near saturation (CNT_W=4): perform 17 reads → o_rd_cnt=15.
